// File: rtl/level_seg_decoder_pkg.sv
// Shared segment-bus constants and FSM state type for the level-to-segment
// encoder/decoder pair.
package level_seg_decoder_pkg;

  // Segment order on the bus: bit6=a ... bit0=g
  localparam logic [6:0] SEG_LVL0  = 7'b0110000;
  localparam logic [6:0] SEG_LVL1  = 7'b1101101;
  localparam logic [6:0] SEG_LVL2  = 7'b1111001;
  localparam logic [6:0] SEG_LVL3  = 7'b0110011;
  localparam logic [6:0] SEG_LVL4  = 7'b1011011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [2:0] LEVEL_MAX = 3'd4;

  // Wide enough for the largest stability window (255 samples)
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    QUALIFY     = 2'd1,
    OUT         = 2'd2,
    WAIT_CHANGE = 2'd3
  } state_e;

endpackage

// File: rtl/level_seg_decoder_lookup.sv
// Combinational reverse map from a 7-segment pattern to a level number,
// with separate flags for a legal digit and for the blank pattern.
module seg_pattern_lookup
  import level_seg_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [2:0] level,
  output logic       hit,
  output logic       blank
);

  always_comb begin
    level = 3'd0;
    hit   = 1'b1;
    blank = (seg == SEG_BLANK);
    case (seg)
      SEG_LVL0: level = 3'd0;
      SEG_LVL1: level = 3'd1;
      SEG_LVL2: level = 3'd2;
      SEG_LVL3: level = 3'd3;
      SEG_LVL4: level = LEVEL_MAX;
      default:  hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/level_seg_decoder.sv
// Receive side of the segment link: qualifies a stable bus pattern, decodes it
// to a level on a valid/ready output and counts stable illegal patterns.
module level_seg_decoder
  import level_seg_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8,
  parameter bit INVERT_SEG    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             seg_en,
  input  logic             out_ready,
  output logic [2:0]       level,
  output logic             level_valid,
  output logic             code_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] STABLE_TARGET = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX       = {ERR_W{1'b1}};

  state_e           state;
  logic [6:0]       seg_cur;
  logic [6:0]       sample;
  logic [6:0]       reported;
  logic [CNT_W-1:0] count;
  logic [2:0]       lut_level;
  logic             lut_hit;
  logic             lut_blank;
  logic             qualify_done;
  logic             report_illegal;
  logic             accept;

  // Common-anode buses are active-low; normalise to active-high here
  assign seg_cur = INVERT_SEG ? ~seg_in : seg_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= SEG_BLANK;
    end else if (seg_en) begin
      sample <= seg_cur;
    end
  end

  seg_pattern_lookup u_lookup (
    .seg   (sample),
    .level (lut_level),
    .hit   (lut_hit),
    .blank (lut_blank)
  );

  // The decision is taken on the held sample once the window is full,
  // independent of whatever arrives on the bus in that same cycle.
  assign qualify_done   = (state == QUALIFY) && seg_en && (count == STABLE_TARGET);
  assign report_illegal = qualify_done && !lut_hit && !lut_blank;
  assign level_valid    = (state == OUT);
  assign accept         = level_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      reported <= SEG_BLANK;
      level    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (seg_en) begin
            state <= QUALIFY;
            count <= CNT_ONE;
          end
        end
        QUALIFY: begin
          if (!seg_en) begin
            state    <= IDLE;
            count    <= '0;
            reported <= SEG_BLANK;
          end else if (qualify_done) begin
            reported <= sample;
            if (lut_hit) begin
              level <= lut_level;
              state <= OUT;
            end else begin
              state <= WAIT_CHANGE;
            end
          end else if (seg_cur == sample) begin
            count <= count + CNT_ONE;
          end else begin
            count <= CNT_ONE;
          end
        end
        OUT: begin
          // Bus is ignored here; only the consumer handshake moves us on
          if (accept) begin
            if (seg_en) begin
              state <= WAIT_CHANGE;
            end else begin
              state    <= IDLE;
              count    <= '0;
              reported <= SEG_BLANK;
            end
          end
        end
        WAIT_CHANGE: begin
          if (!seg_en) begin
            state    <= IDLE;
            count    <= '0;
            reported <= SEG_BLANK;
          end else if (seg_cur != reported) begin
            state <= QUALIFY;
            count <= CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // The pulse still fires when the counter is already saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_err  <= 1'b0;
      err_count <= '0;
    end else begin
      code_err <= report_illegal;
      if (report_illegal && (err_count != ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_level_seg_decoder.sv
// Self-checking bench for level_seg_decoder: directed scenarios plus random
// bus traffic compared against a run-length reference model.
module tb_level_seg_decoder;

  localparam int S       = 4;
  localparam int ERR_MAX = 255;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       seg_en;
  logic       out_ready;
  logic [2:0] level;
  logic       level_valid;
  logic       code_err;
  logic [7:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  bit [6:0] legal_pat [5] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011};

  // Reference model: run length of the current candidate and last reported pattern
  bit       m_valid;
  bit [2:0] m_level;
  bit       m_err;
  int       m_errcnt;
  bit [6:0] m_cand;
  bit [6:0] m_last;
  int       m_run;
  bit       m_waiting;

  level_seg_decoder #(
    .STABLE_CYCLES (S),
    .ERR_W         (8),
    .INVERT_SEG    (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .seg_en      (seg_en),
    .out_ready   (out_ready),
    .level       (level),
    .level_valid (level_valid),
    .code_err    (code_err),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // -1 for an illegal pattern, -2 for blank, otherwise the level
  function automatic int ref_level(input bit [6:0] p);
    if (p == 7'b0) return -2;
    for (int i = 0; i < 5; i++) if (legal_pat[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_level = 0; m_err = 0; m_errcnt = 0;
    m_cand = 0; m_last = 0; m_run = 0; m_waiting = 0;
  endtask

  task automatic model_step();
    int lv;
    m_err = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 0;
        m_run = 0;
        m_waiting = seg_en;
        if (!seg_en) m_last = 0;
      end
    end else if (!seg_en) begin
      m_run = 0; m_waiting = 0; m_last = 0;
    end else if (m_run == S) begin
      lv = ref_level(m_cand);
      m_last = m_cand; m_run = 0; m_waiting = 1;
      if (lv >= 0) begin
        m_valid = 1; m_level = 3'(lv);
      end else if (lv == -1) begin
        m_err = 1;
        if (m_errcnt < ERR_MAX) m_errcnt++;
      end
    end else if (m_run == 0) begin
      if (!m_waiting || seg_in != m_last) begin
        m_cand = seg_in; m_run = 1;
      end
    end else if (seg_in == m_cand) begin
      m_run++;
    end else begin
      m_cand = seg_in; m_run = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 0; seg_en = 0; seg_in = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; seg_en = 1; seg_in = 7'b1111001; out_ready = 1;
    model_reset();
    #1;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (level !== 3'd0 || level_valid !== 1'b0 || code_err !== 1'b0 || err_count !== 8'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_hold: level=%0d valid=%0b err=%0b cnt=%0d, expected all zero",
                 level, level_valid, code_err, err_count);
      end
      tick();
    end
    rst_n = 1;
  endtask

  task automatic test_nominal();
    int edges = 0;
    int reports = 0;
    while (edges < 20) begin
      tick();
      edges++;
      if (level_valid) break;
    end
    n_tests++;
    if (level_valid !== 1'b1 || level !== 3'd2 || edges != S + 1) begin
      n_fail++;
      $display("[TB] FAIL nominal_latency: valid=%0b level=%0d edges=%0d, expected valid=1 level=2 edges=%0d",
               level_valid, level, edges, S + 1);
    end
    for (int i = 0; i < 21; i++) begin
      tick();
      if (level_valid) reports++;
      n_tests++;
      if (level_valid !== m_valid || level !== m_level) begin
        n_fail++;
        $display("[TB] FAIL nominal_cycle: valid=%0b level=%0d, expected valid=%0b level=%0d",
                 level_valid, level, m_valid, m_level);
      end
    end
    n_tests++;
    if (reports != 0) begin
      n_fail++;
      $display("[TB] FAIL nominal_no_repeat: reports=%0d, expected 0", reports);
    end
  endtask

  task automatic test_glitch();
    int reports = 0;
    bit [2:0] seen = 0;
    out_ready = 1;
    for (int i = 0; i < 2 + 3 * S; i++) begin
      seg_in = (i < 2) ? 7'b1101101 : 7'b0110011;
      tick();
      if (level_valid) begin
        reports++;
        seen = level;
      end
      n_tests++;
      if (level_valid !== m_valid || level !== m_level) begin
        n_fail++;
        $display("[TB] FAIL glitch_cycle: valid=%0b level=%0d, expected valid=%0b level=%0d",
                 level_valid, level, m_valid, m_level);
      end
    end
    n_tests++;
    if (reports != 1 || seen != 3'd3) begin
      n_fail++;
      $display("[TB] FAIL glitch_reports: reports=%0d level=%0d, expected 1 report of level 3", reports, seen);
    end
  endtask

  task automatic test_illegal();
    int pulses = 0;
    bit [6:0] bad;
    apply_reset();
    seg_en = 1; out_ready = 1; seg_in = 7'b1111111;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (code_err) pulses++;
    end
    n_tests++;
    if (pulses != 1 || err_count !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL illegal_single: pulses=%0d err_count=%0d, expected 1 and 1", pulses, err_count);
    end
    for (int ep = 0; ep < 300; ep++) begin
      do bad = 7'($urandom); while (ref_level(bad) != -1);
      pulses = 0;
      for (int i = 0; i < 2 * (S + 2); i++) begin
        seg_in = (i < S + 2) ? bad : 7'b0;
        tick();
        if (code_err) pulses++;
        n_tests++;
        if (code_err !== m_err || err_count !== 8'(m_errcnt) || level_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL illegal_cycle: err=%0b cnt=%0d valid=%0b, expected err=%0b cnt=%0d valid=0",
                   code_err, err_count, level_valid, m_err, m_errcnt);
        end
      end
      if (ep == 299) begin
        n_tests++;
        if (pulses != 1) begin
          n_fail++;
          $display("[TB] FAIL illegal_pulse_at_max: pulses=%0d, expected 1", pulses);
        end
      end
    end
    n_tests++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("[TB] FAIL illegal_saturate: err_count=%0d, expected 255", err_count);
    end
  endtask

  task automatic test_backpressure();
    int edges = 0;
    apply_reset();
    seg_en = 1; out_ready = 0; seg_in = 7'b1011011;
    while (edges < 20 && !level_valid) begin
      tick();
      edges++;
    end
    n_tests++;
    if (level_valid !== 1'b1 || level !== 3'd4) begin
      n_fail++;
      $display("[TB] FAIL bp_first: valid=%0b level=%0d, expected valid=1 level=4", level_valid, level);
    end
    seg_in = 7'b0110000;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (level_valid !== 1'b1 || level !== 3'd4) begin
        n_fail++;
        $display("[TB] FAIL bp_hold: valid=%0b level=%0d, expected valid=1 level=4", level_valid, level);
      end
    end
    out_ready = 1;
    tick();
    n_tests++;
    if (level_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_accept: valid=%0b, expected 0", level_valid);
    end
    edges = 0;
    while (edges < 20) begin
      tick();
      edges++;
      if (level_valid) break;
    end
    n_tests++;
    if (level_valid !== 1'b1 || level !== 3'd0 || edges != S + 1) begin
      n_fail++;
      $display("[TB] FAIL bp_next: valid=%0b level=%0d edges=%0d, expected valid=1 level=0 edges=%0d",
               level_valid, level, edges, S + 1);
    end
  endtask

  task automatic test_reset_mid_out();
    int edges = 0;
    apply_reset();
    seg_en = 1; out_ready = 0; seg_in = 7'b1111001;
    while (edges < 20 && !level_valid) begin
      tick();
      edges++;
    end
    n_tests++;
    if (level_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_setup: valid=%0b, expected 1", level_valid);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (level_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL midrst_async: valid=%0b level=%0d, expected 0 and 0", level_valid, level);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    edges = 0;
    while (edges < 20) begin
      tick();
      edges++;
      if (level_valid) break;
    end
    n_tests++;
    if (level_valid !== 1'b1 || level !== 3'd2 || edges != S + 1) begin
      n_fail++;
      $display("[TB] FAIL midrst_rereport: valid=%0b level=%0d edges=%0d, expected valid=1 level=2 edges=%0d",
               level_valid, level, edges, S + 1);
    end
  endtask

  task automatic test_random();
    int hold;
    apply_reset();
    for (int ep = 0; ep < 150; ep++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: seg_in = legal_pat[$urandom_range(0, 4)];
        5:             seg_in = 7'b0;
        default:       seg_in = 7'($urandom);
      endcase
      hold = $urandom_range(1, S + 3);
      for (int i = 0; i < hold; i++) begin
        seg_en    = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 9) < 7);
        tick();
        n_tests++;
        if (level_valid !== m_valid || level !== m_level || code_err !== m_err ||
            err_count !== 8'(m_errcnt)) begin
          n_fail++;
          $display("[TB] FAIL random_cycle: valid=%0b level=%0d err=%0b cnt=%0d, expected %0b %0d %0b %0d",
                   level_valid, level, code_err, err_count, m_valid, m_level, m_err, m_errcnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_illegal();
    test_backpressure();
    test_reset_mid_out();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
